intreqarb: RTL and testbench

//  Per-level interrupt source arbiter: sits directly upstream of intctl, one instance per BR level.

---
 rtl/intreqarb_pkg.sv | 16 +
 rtl/intreqarb_if.sv | 26 ++
 rtl/intreqarb_prienc.sv | 23 ++
 rtl/intreqarb.sv | 111 +++++++++++
 tb/tb_intreqarb.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/intreqarb_pkg.sv
// Shared definitions for the per-BR-level interrupt source arbiter.
// State encoding, the "no vector" code, and the bus-vector formatting helper.
package intreqarb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  localparam logic [7:0] INTVEC_NONE = 8'h01;

  // Interrupt vectors are word aligned on the bus, so the two low bits are forced to zero.
  function automatic logic [7:0] bus_vec(input logic [7:0] v);
    return {v[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/intreqarb_if.sv
// Handshake bundle between device sources / intctl and one intreqarb instance.
// The arbiter takes the slave view; whatever drives sources and intctl takes the master view.
interface intreqarb_if #(
  parameter int NSRC = 2
);

  logic [NSRC-1:0]   req_h;
  logic [8*NSRC-1:0] vecs;
  logic              br_h;
  logic              sack_h;
  logic              intr_h;
  logic [7:0]        intvec;
  logic [NSRC-1:0]   ack_h;
  logic [NSRC-1:0]   pend_h;

  modport master (
    output req_h, vecs, br_h, sack_h, intr_h,
    input  intvec, ack_h, pend_h
  );

  modport slave (
    input  req_h, vecs, br_h, sack_h, intr_h,
    output intvec, ack_h, pend_h
  );

endinterface

// File: rtl/intreqarb_prienc.sv
// Fixed-priority encoder: index of the lowest set request bit, plus an any-set flag.
module intreqarb_prienc #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intreqarb.sv
// Per-level interrupt source arbiter feeding intctl: latches source requests and offers the
// winning vector, holding it stable once intctl has started arbitrating for the bus.
module intreqarb
  import intreqarb_pkg::*;
#(
  parameter int NSRC = 2,
  parameter bit EDGE = 1'b1
) (
  input logic       CLOCK,
  input logic       RESET,
  input logic       init_in_h,
  intreqarb_if.slave bus
);

  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [1:0]      state_q;
  logic [SW-1:0]   sel_q;
  logic            wdrn_q;
  logic [7:0]      intvec_q;
  logic [NSRC-1:0] ack_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] req_d_q;

  logic [NSRC-1:0] cand;
  logic [SW-1:0]   win_idx;
  logic            win_any;
  logic [7:0]      win_vec;
  logic            bus_quiet;
  logic            deliver;
  logic            withdraw;
  logic            preempt;
  logic [NSRC-1:0] deliver_v;
  logic [NSRC-1:0] set_v;
  logic [NSRC-1:0] pend_d;

  // Level mode selects straight from the request lines, giving one cycle less latency.
  assign cand = EDGE ? pend_q : bus.req_h;

  intreqarb_prienc #(.N(NSRC)) u_prienc (
    .req (cand),
    .idx (win_idx),
    .any (win_any)
  );

  assign win_vec   = bus_vec(bus.vecs[8*int'(win_idx) +: 8]);
  assign bus_quiet = ~bus.br_h & ~bus.sack_h;
  assign deliver   = (state_q == ST_OFFER) & ~wdrn_q & bus.intr_h;
  assign withdraw  = ~bus.req_h[sel_q];
  assign preempt   = bus_quiet & win_any & (win_idx < sel_q);

  always_comb begin
    deliver_v = '0;
    if (deliver) deliver_v[sel_q] = 1'b1;
    set_v  = EDGE ? (bus.req_h & ~req_d_q) : bus.req_h;
    // Withdrawal or delivery clears, and clearing beats a simultaneous set.
    pend_d = (pend_q | set_v) & bus.req_h & ~deliver_v;
  end

  // NOTE: all state updates below use non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      wdrn_q   <= 1'b0;
      intvec_q <= INTVEC_NONE;
      ack_q    <= '0;
      pend_q   <= '0;
      // Seed history with the live level so a request held through reset is not a new edge.
      req_d_q  <= bus.req_h;
    end else begin
      pend_q  <= pend_d;
      req_d_q <= bus.req_h;
      ack_q   <= deliver_v;
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            sel_q    <= win_idx;
            intvec_q <= win_vec;
            wdrn_q   <= 1'b0;
            state_q  <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (deliver) begin
            intvec_q <= INTVEC_NONE;
            state_q  <= ST_XFER;
          end else if (wdrn_q || withdraw) begin
            // Stay locked until intctl has dropped br/sack, then rearbitrate from scratch.
            wdrn_q   <= 1'b1;
            intvec_q <= INTVEC_NONE;
            if (bus_quiet) state_q <= ST_IDLE;
          end else if (preempt) begin
            sel_q    <= win_idx;
            intvec_q <= win_vec;
          end
        end
        ST_XFER: begin
          if (!bus.intr_h) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.intvec = intvec_q;
  assign bus.ack_h  = ack_q;
  assign bus.pend_h = pend_q;

endmodule

// File: tb/tb_intreqarb.sv
// Bench for intreqarb: an edge-mode and a level-mode instance share stimulus; each cycle both are
// compared with a transaction-level model, plus directed checks against hand-derived constants.
module tb_intreqarb;
  import intreqarb_pkg::*;

  localparam int NSRC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             init;
  logic [NSRC-1:0]  req;
  logic [8*NSRC-1:0] vecs;
  logic             br;
  logic             sack;
  logic             intr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  intreqarb_if #(.NSRC(NSRC)) if_e ();
  intreqarb_if #(.NSRC(NSRC)) if_l ();

  assign if_e.req_h  = req;
  assign if_e.vecs   = vecs;
  assign if_e.br_h   = br;
  assign if_e.sack_h = sack;
  assign if_e.intr_h = intr;
  assign if_l.req_h  = req;
  assign if_l.vecs   = vecs;
  assign if_l.br_h   = br;
  assign if_l.sack_h = sack;
  assign if_l.intr_h = intr;

  intreqarb #(.NSRC(NSRC), .EDGE(1'b1)) u_edge (
    .CLOCK(clk), .RESET(rst), .init_in_h(init), .bus(if_e)
  );
  intreqarb #(.NSRC(NSRC), .EDGE(1'b0)) u_level (
    .CLOCK(clk), .RESET(rst), .init_in_h(init), .bus(if_l)
  );

  // Reference model, one slot per instance (0 = edge mode, 1 = level mode).
  // phase: 0 waiting for a request, 1 vector on offer, 2 transfer in progress.
  int              phase   [2];
  int              offered [2];
  bit              gone    [2];
  logic [NSRC-1:0] pend_m  [2];
  logic [NSRC-1:0] prev_m  [2];
  logic [NSRC-1:0] ack_m   [2];
  logic [7:0]      vec_m   [2];

  function automatic logic [7:0] vec_of(input int i);
    logic [7:0] v;
    v = vecs[8*i +: 8];
    return v & 8'hFC;
  endfunction

  task automatic model_step(input int m);
    logic [NSRC-1:0] visible;
    int first;
    int delivered;
    if (rst || init) begin
      phase[m] = 0; offered[m] = 0; gone[m] = 1'b0;
      pend_m[m] = '0; prev_m[m] = req; ack_m[m] = '0; vec_m[m] = 8'h01;
      return;
    end
    visible   = (m == 0) ? pend_m[m] : req;
    first     = -1;
    delivered = -1;
    for (int i = NSRC - 1; i >= 0; i--) if (visible[i]) first = i;
    ack_m[m] = '0;
    if (phase[m] == 0) begin
      if (first >= 0) begin
        offered[m] = first; vec_m[m] = vec_of(first); phase[m] = 1; gone[m] = 1'b0;
      end
    end else if (phase[m] == 1) begin
      if (intr && !gone[m]) begin
        delivered = offered[m];
        ack_m[m][offered[m]] = 1'b1;
        vec_m[m] = 8'h01; phase[m] = 2;
      end else if (gone[m] || !req[offered[m]]) begin
        gone[m] = 1'b1; vec_m[m] = 8'h01;
        if (!br && !sack) phase[m] = 0;
      end else if (!br && !sack && first >= 0 && first < offered[m]) begin
        offered[m] = first; vec_m[m] = vec_of(first);
      end
    end else begin
      if (!intr) phase[m] = 0;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (!req[i] || i == delivered) pend_m[m][i] = 1'b0;
      else if (m == 1 || !prev_m[m][i]) pend_m[m][i] = 1'b1;
    end
    prev_m[m] = req;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("edge.intvec",  if_e.intvec,            vec_m[0]);
    check("edge.ack",     {6'b0, if_e.ack_h},     {6'b0, ack_m[0]});
    check("edge.pend",    {6'b0, if_e.pend_h},    {6'b0, pend_m[0]});
    check("level.intvec", if_l.intvec,            vec_m[1]);
    check("level.ack",    {6'b0, if_l.ack_h},     {6'b0, ack_m[1]});
    check("level.pend",   {6'b0, if_l.pend_h},    {6'b0, pend_m[1]});
  endtask

  task automatic quiesce();
    req = '0; br = 1'b0; sack = 1'b0; intr = 1'b0; init = 1'b0;
    rst = 1'b1; cycle();
    rst = 1'b0; cycle();
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; req = '0; br = 1'b0; sack = 1'b0; intr = 1'b0;
    vecs = {8'o064, 8'o060};
    for (int m = 0; m < 2; m++) begin
      phase[m] = 0; offered[m] = 0; gone[m] = 1'b0;
      pend_m[m] = '0; prev_m[m] = '0; ack_m[m] = '0; vec_m[m] = 8'h01;
    end
    @(negedge clk);
    cycle(); cycle();
    check("reset.intvec", if_e.intvec, INTVEC_NONE);
    check("reset.pend",   {6'b0, if_e.pend_h}, 8'h00);
    rst = 1'b0;

    // Single source through a full intctl handshake.
    cycle();
    req = 2'b01; cycle(); cycle();
    check("single.offer", if_e.intvec, 8'o060);
    br = 1'b1; cycle();
    br = 1'b0; sack = 1'b1; cycle();
    check("single.held", if_e.intvec, 8'o060);
    sack = 1'b0; intr = 1'b1; cycle();
    check("single.ack",   {6'b0, if_e.ack_h}, 8'h01);
    check("single.clear", if_e.intvec, INTVEC_NONE);
    cycle();
    check("single.ack1cyc", {6'b0, if_e.ack_h}, 8'h00);
    intr = 1'b0; cycle(); cycle();
    check("single.idle", if_e.intvec, INTVEC_NONE);

    // Simultaneous requests: index 0 wins, index 1 follows the transfer.
    quiesce();
    req = 2'b11; cycle(); cycle();
    check("prio.first", if_e.intvec, 8'o060);
    intr = 1'b1; cycle();
    check("prio.ack0", {6'b0, if_e.ack_h}, 8'h01);
    intr = 1'b0; cycle(); cycle();
    check("prio.second", if_e.intvec, 8'o064);
    intr = 1'b1; cycle();
    check("prio.ack1", {6'b0, if_e.ack_h}, 8'h02);
    intr = 1'b0; cycle();

    // Once br is up, a later higher-priority request must not displace the offer.
    quiesce();
    req = 2'b10; cycle(); cycle();
    check("lock.offer", if_e.intvec, 8'o064);
    br = 1'b1; req = 2'b11; cycle(); cycle();
    check("lock.held", if_e.intvec, 8'o064);
    br = 1'b0; intr = 1'b1; cycle();
    check("lock.ack", {6'b0, if_e.ack_h}, 8'h02);
    intr = 1'b0; cycle(); cycle();
    check("lock.next", if_e.intvec, 8'o060);

    // Withdrawal while intctl holds sack.
    quiesce();
    req = 2'b01; cycle(); cycle();
    check("wd.offer", if_e.intvec, 8'o060);
    sack = 1'b1; cycle();
    req = 2'b00; cycle();
    check("wd.none",  if_e.intvec, INTVEC_NONE);
    check("wd.noack", {6'b0, if_e.ack_h}, 8'h00);
    cycle();
    sack = 1'b0; cycle();
    req = 2'b01; cycle(); cycle();
    check("wd.reoffer", if_e.intvec, 8'o060);

    // RESET mid-transfer, then INIT mid-transfer, with the request level held.
    quiesce();
    req = 2'b01; cycle(); cycle();
    intr = 1'b1; cycle();
    rst = 1'b1; cycle();
    check("rstx.intvec", if_e.intvec, INTVEC_NONE);
    check("rstx.pend",   {6'b0, if_e.pend_h}, 8'h00);
    check("rstx.ack",    {6'b0, if_e.ack_h}, 8'h00);
    rst = 1'b0; cycle(); cycle();
    check("rstx.nopend", {6'b0, if_e.pend_h}, 8'h00);
    check("rstx.nooffer", if_e.intvec, INTVEC_NONE);
    intr = 1'b0; req = 2'b00; cycle();
    req = 2'b01; cycle(); cycle();
    check("rstx.repend", if_e.intvec, 8'o060);
    intr = 1'b1; cycle();
    init = 1'b1; cycle();
    check("initx.intvec", if_e.intvec, INTVEC_NONE);
    check("initx.ack",    {6'b0, if_e.ack_h}, 8'h00);
    init = 1'b0; intr = 1'b0; cycle(); cycle();
    check("initx.nopend", {6'b0, if_e.pend_h}, 8'h00);
    check("initx.nooffer", if_e.intvec, INTVEC_NONE);

    // Level mode: held request is re-offered after the transfer completes.
    quiesce();
    req = 2'b10; cycle();
    check("level.offer", if_l.intvec, 8'o064);
    intr = 1'b1; cycle();
    check("level.ack", {6'b0, if_l.ack_h}, 8'h02);
    intr = 1'b0; cycle(); cycle();
    check("level.reoffer", if_l.intvec, 8'o064);

    // Randomized traffic against the model.
    quiesce();
    for (int n = 0; n < 2000; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      init = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = NSRC'($urandom);
      if ($urandom_range(0, 31) == 0) vecs = 16'($urandom);
      br   = ($urandom_range(0, 3) == 0);
      sack = ($urandom_range(0, 4) == 0);
      intr = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
